softmax_sched: RTL



---
 rtl/softmax_pkg.sv | 22 ++
 rtl/softmax_buf.sv | 44 ++++
 rtl/softmax_sched.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/softmax_pkg.sv
// softmax_sched shared types and constants.
// State encoding, data width and index-width helper.
package softmax_pkg;

   localparam int FP_W = 32;

   typedef enum logic [1:0] {
      LOAD,
      ISSUE,
      WAIT,
      OUT
   } state_t;

   // Index width for a table of n entries, never below 1 bit.
   function automatic int clog2(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/softmax_buf.sv
// Frame buffer of N_CLASSES FP32 words.
// Pair-granular write port, pair read port, single-word read port.
module softmax_buf
   import softmax_pkg::*;
#(
   parameter int N_CLASSES = 10,
   parameter int IW        = clog2(N_CLASSES)
) (
   input  logic            clk,
   input  logic            i_we,
   input  logic [IW-1:0]   i_wpair,
   input  logic [1:0]      i_wmask,
   input  logic [FP_W-1:0] i_wd0,
   input  logic [FP_W-1:0] i_wd1,
   input  logic [IW-1:0]   i_pair,
   output logic [FP_W-1:0] o_p0,
   output logic [FP_W-1:0] o_p1,
   input  logic [IW-1:0]   i_addr,
   output logic [FP_W-1:0] o_d
);

   logic [FP_W-1:0] r_mem [N_CLASSES];

   logic [IW-1:0] w_wa0;
   logic [IW-1:0] w_wa1;
   logic [IW-1:0] w_ra0;
   logic [IW-1:0] w_ra1;

   assign w_wa0 = i_wpair << 1;
   assign w_wa1 = w_wa0 | IW'(1);
   assign w_ra0 = i_pair << 1;
   assign w_ra1 = w_ra0 | IW'(1);

   // Write the even and/or odd word of the addressed pair.
   always_ff @(posedge clk) begin
      if (i_we && i_wmask[0]) r_mem[w_wa0] <= i_wd0;
      if (i_we && i_wmask[1]) r_mem[w_wa1] <= i_wd1;
   end

   assign o_p0 = r_mem[w_ra0];
   assign o_p1 = r_mem[w_ra1];
   assign o_d  = r_mem[i_addr];

endmodule

// File: rtl/softmax_sched.sv
// Frame controller for the two-input Softmax unit.
// Loads logits, issues pairs, gathers results, streams them out.
module softmax_sched
   import softmax_pkg::*;
#(
   parameter int N_CLASSES  = 10,
   parameter int SM_LATENCY = 4,
   parameter int TO_MARGIN  = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [FP_W-1:0] in_data,
   output logic            sm_valid_in,
   output logic [FP_W-1:0] sm_i0,
   output logic [FP_W-1:0] sm_i1,
   input  logic [FP_W-1:0] sm_o0,
   input  logic [FP_W-1:0] sm_o1,
   input  logic            sm_valid_out,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [FP_W-1:0] out_data,
   output logic            out_last,
   output logic            busy,
   output logic            err
);

   localparam int IW     = clog2(N_CLASSES);
   localparam int NP     = N_CLASSES / 2;
   localparam int TO_LIM = SM_LATENCY + TO_MARGIN;
   localparam int TW     = clog2(TO_LIM + 1);

   state_t        r_state;
   logic [IW-1:0] r_wr_cnt;
   logic [IW-1:0] r_iss_cnt;
   logic [IW-1:0] r_res_cnt;
   logic [IW-1:0] r_rd_cnt;
   logic [TW-1:0] r_to_cnt;
   logic          r_err;

   logic            w_load;
   logic            w_issue;
   logic            w_out;
   logic            w_cap_win;
   logic            w_cap;
   logic            w_spur;
   logic [IW-1:0]   w_res_nxt;
   logic            w_res_done;
   logic            w_wr_last;
   logic            w_rd_last;
   logic [FP_W-1:0] w_lp0;
   logic [FP_W-1:0] w_lp1;
   logic [FP_W-1:0] w_rd;
   logic [FP_W-1:0] w_unused_l;
   logic [FP_W-1:0] w_unused_r0;
   logic [FP_W-1:0] w_unused_r1;

   assign w_load     = (r_state == LOAD);
   assign w_issue    = (r_state == ISSUE);
   assign w_out      = (r_state == OUT);
   assign w_cap_win  = w_issue || (r_state == WAIT);
   assign w_cap      = sm_valid_out && w_cap_win
                       && (r_res_cnt != IW'(NP));
   assign w_spur     = sm_valid_out && !w_cap;
   assign w_res_nxt  = r_res_cnt + IW'(w_cap);
   assign w_res_done = (w_res_nxt == IW'(NP));
   assign w_wr_last  = (r_wr_cnt == IW'(N_CLASSES - 1));
   assign w_rd_last  = (r_rd_cnt == IW'(N_CLASSES - 1));

   softmax_buf #(
      .N_CLASSES (N_CLASSES)
   ) lbuf (
      .clk     (clk),
      .i_we    (w_load && in_valid),
      .i_wpair (r_wr_cnt >> 1),
      .i_wmask (r_wr_cnt[0] ? 2'b10 : 2'b01),
      .i_wd0   (in_data),
      .i_wd1   (in_data),
      .i_pair  (r_iss_cnt),
      .o_p0    (w_lp0),
      .o_p1    (w_lp1),
      .i_addr  (r_rd_cnt),
      .o_d     (w_unused_l)
   );

   softmax_buf #(
      .N_CLASSES (N_CLASSES)
   ) rbuf (
      .clk     (clk),
      .i_we    (w_cap),
      .i_wpair (r_res_cnt),
      .i_wmask (2'b11),
      .i_wd0   (sm_o0),
      .i_wd1   (sm_o1),
      .i_pair  ('0),
      .o_p0    (w_unused_r0),
      .o_p1    (w_unused_r1),
      .i_addr  (r_rd_cnt),
      .o_d     (w_rd)
   );

   assign in_ready    = w_load;
   assign busy        = !w_load;
   assign sm_valid_in = w_issue;
   assign sm_i0       = w_issue ? w_lp0 : '0;
   assign sm_i1       = w_issue ? w_lp1 : '0;
   assign out_valid   = w_out;
   assign out_data    = w_out ? w_rd : '0;
   assign out_last    = w_out && w_rd_last;
   assign err         = r_err;

   // Frame sequencing, result counting, timeout and sticky error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= LOAD;
         r_wr_cnt  <= '0;
         r_iss_cnt <= '0;
         r_res_cnt <= '0;
         r_rd_cnt  <= '0;
         r_to_cnt  <= '0;
         r_err     <= 1'b0;
      end else begin
         if (w_spur) r_err <= 1'b1;
         if (w_cap) r_res_cnt <= w_res_nxt;
         unique case (r_state)
            LOAD: begin
               if (in_valid) begin
                  if (w_wr_last) begin
                     r_wr_cnt  <= '0;
                     r_iss_cnt <= '0;
                     r_res_cnt <= '0;
                     r_state   <= ISSUE;
                  end else begin
                     r_wr_cnt <= r_wr_cnt + IW'(1);
                  end
               end
            end
            ISSUE: begin
               if (r_iss_cnt == IW'(NP - 1)) begin
                  r_iss_cnt <= '0;
                  r_to_cnt  <= '0;
                  r_state   <= WAIT;
               end else begin
                  r_iss_cnt <= r_iss_cnt + IW'(1);
               end
            end
            WAIT: begin
               if (w_res_done) begin
                  r_res_cnt <= '0;
                  r_to_cnt  <= '0;
                  r_state   <= OUT;
               end else if (r_to_cnt == TW'(TO_LIM - 1)) begin
                  r_err     <= 1'b1;
                  r_res_cnt <= '0;
                  r_to_cnt  <= '0;
                  r_state   <= LOAD;
               end else begin
                  r_to_cnt <= r_to_cnt + TW'(1);
               end
            end
            OUT: begin
               if (out_ready) begin
                  if (w_rd_last) begin
                     r_rd_cnt <= '0;
                     r_state  <= LOAD;
                  end else begin
                     r_rd_cnt <= r_rd_cnt + IW'(1);
                  end
               end
            end
            default: r_state <= LOAD;
         endcase
      end
   end

endmodule
